// File: rtl/reg_file_sb.sv
// Register file with a pending-write scoreboard and a sequenced clear engine.
// Define RF_BYPASS_EN to forward same-cycle write data and hide busy on a matching read.
module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic w_idle;
    logic w_commit;
    logic w_issue;
    logic w_hit1;
    logic w_hit2;

    assign w_idle   = (r_state == IDLE);
    assign w_commit = we && (wa != '0) && w_idle;
    assign w_issue  = iss_v && (iss_rd != '0) && w_idle;

    // The issue set is written after the commit clear so a same-address set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= ONE;
            r_pend  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_commit) begin
                        r_regs[wa] <= wd;
                        r_pend[wa] <= 1'b0;
                    end
                    if (w_issue) begin
                        r_pend[iss_rd] <= 1'b1;
                    end
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= ONE;
                    end
                end
                CLEAR: begin
                    r_regs[r_cnt] <= '0;
                    r_pend[r_cnt] <= 1'b0;
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= ONE;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= ONE;
                end
            endcase
        end
    end

`ifdef RF_BYPASS_EN
    assign w_hit1 = w_commit && (wa == ra1);
    assign w_hit2 = w_commit && (wa == ra2);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    assign rd1      = (ra1 == '0) ? '0 : (w_hit1 ? wd : r_regs[ra1]);
    assign rd2      = (ra2 == '0) ? '0 : (w_hit2 ? wd : r_regs[ra2]);
    assign rs1_busy = (ra1 != '0) && !w_hit1 && r_pend[ra1];
    assign rs2_busy = (ra2 != '0) && !w_hit2 && r_pend[ra2];
    assign clr_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, hand-written clear/reset
// sequences, then random traffic against a behavioural model. Honours RF_BYPASS_EN.
module tb_reg_file_sb;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          iss_v;
    logic [AW-1:0] iss_rd;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          clr_req;
    logic          clr_busy;

    int checks   = 0;
    int failures = 0;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .iss_v(iss_v), .iss_rd(iss_rd), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic          iss;
        logic [AW-1:0] issRd;
        logic [DW-1:0] expRd1;
        logic [DW-1:0] expRd2;
        logic          expB1;
        logic          expB2;
    } vec_t;

    // Behavioural model: register contents, pending flags and clear progress.
    logic [DW-1:0] mRegs [DEPTH];
    bit            mPend [DEPTH];
    bit            mClearing;
    int            mNext;

    function automatic vec_t mkVec(logic w, int a, logic [DW-1:0] d, int r1, int r2,
                                   logic i, int ir, logic [DW-1:0] e1, logic [DW-1:0] e2,
                                   logic b1, logic b2);
        vec_t v;
        v.we = w; v.wa = AW'(a); v.wd = d; v.ra1 = AW'(r1); v.ra2 = AW'(r2);
        v.iss = i; v.issRd = AW'(ir); v.expRd1 = e1; v.expRd2 = e2;
        v.expB1 = b1; v.expB2 = b2;
        return v;
    endfunction

    task automatic applyStimulus(input logic iWe, input int iWa, input logic [DW-1:0] iWd,
                                 input int iRa1, input int iRa2, input logic iIss,
                                 input int iIssRd, input logic iClr);
        @(negedge clk);
        we = iWe; wa = AW'(iWa); wd = iWd; ra1 = AW'(iRa1); ra2 = AW'(iRa2);
        iss_v = iIss; iss_rd = AW'(iIssRd); clr_req = iClr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mRegs[i] = '0;
            mPend[i] = 1'b0;
        end
        mClearing = 1'b0;
        mNext     = 1;
    endtask

    function automatic bit modelHit(input logic [AW-1:0] ra);
        return BYP && we && (wa != 0) && !mClearing && (wa == ra);
    endfunction

    function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
        if (modelHit(ra)) return wd;
        return mRegs[ra];
    endfunction

    function automatic logic modelBusy(input logic [AW-1:0] ra);
        if (ra == 0 || modelHit(ra)) return 1'b0;
        return mPend[ra];
    endfunction

    task automatic modelStep();
        if (mClearing) begin
            mRegs[mNext] = '0;
            mPend[mNext] = 1'b0;
            if (mNext == DEPTH - 1) mClearing = 1'b0;
            else mNext++;
        end else begin
            if (we && wa != 0) begin
                mRegs[wa] = wd;
                mPend[wa] = 1'b0;
            end
            if (iss_v && iss_rd != 0) mPend[iss_rd] = 1'b1;
            if (clr_req) begin
                mClearing = 1'b1;
                mNext     = 1;
            end
        end
    endtask

    initial begin
        vec_t vecs[15];

        rst = 1'b1; we = 0; wa = 0; wd = 0; ra1 = 3; ra2 = 5;
        iss_v = 0; iss_rd = 0; clr_req = 0;
        #12;
        checkOutput("reset_rd1", 32'(rd1), 0);
        checkOutput("reset_rd2", 32'(rd2), 0);
        checkOutput("reset_busy", {30'd0, rs1_busy, rs2_busy}, 0);
        checkOutput("reset_clr_busy", 32'(clr_busy), 0);
        rst = 1'b0;

        vecs[0]  = mkVec(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mkVec(1, 3, 16'hABCD, 3, 0, 0, 0, BYP ? 16'hABCD : 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mkVec(1, 0, 16'h1234, 3, 0, 0, 0, 16'hABCD, 16'h0000, 0, 0);
        vecs[3]  = mkVec(1, 5, 16'h00FF, 5, 3, 0, 0, BYP ? 16'h00FF : 16'h0000, 16'hABCD, 0, 0);
        vecs[4]  = mkVec(0, 0, 16'h0000, 5, 0, 0, 0, 16'h00FF, 16'h0000, 0, 0);
        vecs[5]  = mkVec(0, 0, 16'h0000, 4, 0, 1, 4, 16'h0000, 16'h0000, 0, 0);
        vecs[6]  = mkVec(0, 0, 16'h0000, 4, 0, 0, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[7]  = mkVec(1, 4, 16'h4444, 4, 0, 0, 0, BYP ? 16'h4444 : 16'h0000, 16'h0000, !BYP, 0);
        vecs[8]  = mkVec(0, 0, 16'h0000, 4, 0, 0, 0, 16'h4444, 16'h0000, 0, 0);
        vecs[9]  = mkVec(1, 4, 16'h5555, 4, 4, 1, 4, BYP ? 16'h5555 : 16'h4444,
                         BYP ? 16'h5555 : 16'h4444, 0, 0);
        vecs[10] = mkVec(0, 0, 16'h0000, 4, 0, 0, 0, 16'h5555, 16'h0000, 1, 0);
        vecs[11] = mkVec(0, 0, 16'h0000, 4, 0, 1, 0, 16'h5555, 16'h0000, 1, 0);
        vecs[12] = mkVec(0, 0, 16'h0000, 4, 0, 0, 0, 16'h5555, 16'h0000, 1, 0);
        vecs[13] = mkVec(1, 4, 16'h7777, 4, 6, 1, 6, BYP ? 16'h7777 : 16'h5555, 16'h0000, !BYP, 0);
        vecs[14] = mkVec(0, 0, 16'h0000, 4, 6, 0, 0, 16'h7777, 16'h0000, 0, 1);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].we, int'(vecs[i].wa), vecs[i].wd, int'(vecs[i].ra1),
                          int'(vecs[i].ra2), vecs[i].iss, int'(vecs[i].issRd), 1'b0);
            checkOutput($sformatf("vec%0d_rd1", i), 32'(rd1), 32'(vecs[i].expRd1));
            checkOutput($sformatf("vec%0d_rd2", i), 32'(rd2), 32'(vecs[i].expRd2));
            checkOutput($sformatf("vec%0d_busy1", i), 32'(rs1_busy), 32'(vecs[i].expB1));
            checkOutput($sformatf("vec%0d_busy2", i), 32'(rs2_busy), 32'(vecs[i].expB2));
            @(posedge clk);
        end

        // Fill r1..r7, then start a clear together with a write to r1 and an issue to r7.
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1, i, 16'h1000 + DW'(i) * 16'h0111, 0, 0, 0, 0, 0);
            @(posedge clk);
        end
        applyStimulus(1, 1, 16'hBEEF, 1, 7, 1, 7, 1);
        checkOutput("clr_start_busy", 32'(clr_busy), 0);
        checkOutput("clr_start_rd1", 32'(rd1), BYP ? 32'hBEEF : 32'h1111);
        checkOutput("clr_start_rd2", 32'(rd2), 32'h1777);
        @(posedge clk);
        for (int k = 1; k < DEPTH; k++) begin
            applyStimulus(1, 7, 16'hFFFF, 1, 7, 1, 3, 1);
            checkOutput($sformatf("clr%0d_busy", k), 32'(clr_busy), 1);
            checkOutput($sformatf("clr%0d_rd1", k), 32'(rd1), (k == 1) ? 32'hBEEF : 32'h0);
            checkOutput($sformatf("clr%0d_rd2", k), 32'(rd2), 32'h1777);
            checkOutput($sformatf("clr%0d_rs2busy", k), 32'(rs2_busy), 1);
            @(posedge clk);
        end
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 0, 16'h0, a, a, 0, 0, 0);
            checkOutput($sformatf("post_clr_r%0d", a), 32'(rd1), 0);
            checkOutput($sformatf("post_clr_busy%0d", a), 32'(rs1_busy), 0);
            checkOutput($sformatf("post_clr_clrbusy%0d", a), 32'(clr_busy), 0);
            @(posedge clk);
        end

        // Asynchronous reset in the middle of a clear with pend[5] set.
        applyStimulus(1, 3, 16'h3333, 0, 0, 1, 5, 0);
        @(posedge clk);
        applyStimulus(0, 0, 16'h0, 3, 5, 0, 0, 1);
        @(posedge clk);
        applyStimulus(0, 0, 16'h0, 3, 5, 0, 0, 0);
        @(posedge clk);
        #2;
        checkOutput("pre_rst_clr_busy", 32'(clr_busy), 1);
        checkOutput("pre_rst_rd1", 32'(rd1), 32'h3333);
        checkOutput("pre_rst_busy2", 32'(rs2_busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_rd1", 32'(rd1), 0);
        checkOutput("mid_rst_busy2", 32'(rs2_busy), 0);
        checkOutput("mid_rst_clr_busy", 32'(clr_busy), 0);
        #1;
        rst = 1'b0;
        applyStimulus(1, 2, 16'h2222, 2, 5, 0, 0, 0);
        @(posedge clk);
        applyStimulus(0, 0, 16'h0, 2, 5, 0, 0, 0);
        checkOutput("post_rst_write", 32'(rd1), 32'h2222);
        checkOutput("post_rst_busy2", 32'(rs2_busy), 0);
        checkOutput("post_rst_clr_busy", 32'(clr_busy), 0);

        // Random traffic against the model.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
        for (int n = 0; n < 600; n++) begin
            applyStimulus(1'($urandom_range(1, 0)), int'($urandom_range(DEPTH - 1, 0)), DW'($urandom),
                          int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(DEPTH - 1, 0)),
                          ($urandom_range(9, 0) < 3), int'($urandom_range(DEPTH - 1, 0)),
                          ($urandom_range(39, 0) == 0));
            checkOutput($sformatf("rnd%0d_rd1", n), 32'(rd1), 32'(modelRead(ra1)));
            checkOutput($sformatf("rnd%0d_rd2", n), 32'(rd2), 32'(modelRead(ra2)));
            checkOutput($sformatf("rnd%0d_busy1", n), 32'(rs1_busy), 32'(modelBusy(ra1)));
            checkOutput($sformatf("rnd%0d_busy2", n), 32'(rs2_busy), 32'(modelBusy(ra2)));
            checkOutput($sformatf("rnd%0d_clr_busy", n), 32'(clr_busy), 32'(mClearing));
            modelStep();
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 16, which sets the register data width in bits.
REQ-002 The block SHALL have the parameter ADDR_W, default 3, which sets the address width; DEPTH = 2**ADDR_W registers.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide: the reset, asynchronous and active-high.
REQ-005 The port we SHALL be an input, 1 bit wide: write enable.
REQ-006 The port wa SHALL be an input, ADDR_W bits wide: the write address.
REQ-007 The port wd SHALL be an input, DATA_W bits wide: the write data.
REQ-008 The ports ra1 and ra2 SHALL be inputs, ADDR_W bits wide: the read addresses.
REQ-009 The ports rd1 and rd2 SHALL be outputs, DATA_W bits wide: the combinational read data.
REQ-010 The port iss_v SHALL be an input, 1 bit wide: an issue strobe that marks a destination register pending.
REQ-011 The port iss_rd SHALL be an input, ADDR_W bits wide: the issued destination address.
REQ-012 The ports rs1_busy and rs2_busy SHALL be outputs, 1 bit wide: ra1/ra2 has an outstanding write.
REQ-013 The port clr_req SHALL be an input, 1 bit wide: a request for a sequenced clear of all registers.
REQ-014 The port clr_busy SHALL be an output, 1 bit wide: high while the clear sequence runs.

Function
REQ-015 Register 0 SHALL always read 0; writes to address 0 and issues to address 0 SHALL be ignored; rs*_busy for address 0 SHALL be 0.
REQ-016 A write SHALL commit Register[wa] <= wd at the rising edge when we=1, wa!=0 and clr_busy=0.
REQ-017 rd1/rd2 SHALL be combinational with 0-cycle latency: rdN = Register[raN], subject to REQ-018 and REQ-015.
REQ-018 Write forwarding SHALL follow REQ-027/REQ-028.
REQ-019 The scoreboard SHALL be a DEPTH-bit pend vector:
- iss_v=1 with iss_rd!=0 sets pend[iss_rd] at the edge.
- A committed write clears pend[wa].
- When set and clear hit the same address in the same cycle, set SHALL win.
- When they hit different addresses, both SHALL apply.
REQ-020 rsN_busy SHALL equal pend[raN], masked per REQ-027/REQ-028.
REQ-021 The clear FSM SHALL have two states, IDLE and CLEAR:
- IDLE->CLEAR on clr_req=1.
- In CLEAR, an ADDR_W-bit counter starts at 1 and zeroes Register[cnt] and pend[cnt] at each edge.
- CLEAR->IDLE after the cycle with cnt=DEPTH-1, i.e. DEPTH-1 cycles in CLEAR.
REQ-022 clr_busy SHALL be 1 exactly while in CLEAR.
- we and iss_v SHALL be ignored during CLEAR.
- clr_req SHALL be ignored in CLEAR.
- A write asserted in the same cycle as clr_req in IDLE SHALL still commit.
REQ-023 Reads during CLEAR SHALL return current contents, so already-cleared registers read 0 and not-yet-cleared ones keep old values; rs*_busy SHALL track pend likewise.
REQ-024 The counter SHALL NOT wrap through 0; the FSM exits at DEPTH-1.

Reset
REQ-025 On rst=1, immediately and asynchronously:
- all registers SHALL be 0;
- pend SHALL be all-zero;
- the FSM SHALL be IDLE and the counter SHALL be 1;
- outputs SHALL be rd1=rd2=0, rs1_busy=rs2_busy=0, clr_busy=0.
REQ-026 rst asserted mid-CLEAR SHALL abort the sequence to IDLE; after rst deasserts, the next edge SHALL accept new operations.

Configuration
REQ-027 With macro RF_BYPASS_EN defined: when we=1, wa!=0, clr_busy=0 and wa==raN, rdN SHALL equal wd combinationally and rsN_busy SHALL be 0 in that cycle.
REQ-028 Without RF_BYPASS_EN: rdN SHALL return the pre-write value and rsN_busy SHALL equal pend[raN] until the edge after the write.

Verification
REQ-029 Write 16'hABCD to r3, then read ra1=3 next cycle -> rd1=16'hABCD; write 16'h1234 to r0 -> rd2(ra2=0)=0.
REQ-030 Write r5=16'h00FF with ra1=5 in the same cycle -> rd1=16'h00FF (RF_BYPASS_EN) / old value (undefined macro); next cycle 16'h00FF in both builds.
REQ-031 iss_v with iss_rd=4 -> rs1_busy=1 with ra1=4 next cycle; write r4 with ra1=4 -> rs1_busy=0 in the same cycle (bypass) or the next cycle (no bypass); iss_v r4 plus write r4 in the same cycle -> pend[4] stays 1.
REQ-032 Fill r1..r7 with nonzero data, then pulse clr_req -> clr_busy=1 for 7 cycles, r1 reads 0 after the first edge, r7 keeps its value until the 7th edge; we pulses during CLEAR are ignored; clr_busy=0 afterwards with all registers 0.
REQ-033 Assert rst asynchronously mid-CLEAR (between edges), with pend nonzero -> rd*=0, rs*_busy=0, clr_busy=0 before the next clk edge; a write on the first edge after deassertion commits.
